// File: rtl/alu_lockstep_checker.sv
// Dual-lane lockstep ALU with result comparison, sticky error, saturating mismatch counter and OK/FAIL monitor; optional ALU_CHK_FAULT_INJ_EN adds fault_inj.
// Latency in_valid -> out_valid is 2 cycles at one set per cycle; there is no backpressure, so results must be consumed when valid.
module alu_lockstep_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       sel0,
  input  logic [1:0]       sel1,
`ifdef ALU_CHK_FAULT_INJ_EN
  input  logic             fault_inj,
`endif
  input  logic             clr_err,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             carry0,
  output logic             carry1,
  output logic [WIDTH-1:0] diff,
  output logic             carry_diff,
  output logic             out_valid,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic             mon_state
);

  typedef enum logic {MON_OK = 1'b0, MON_FAIL = 1'b1} mon_state_t;

  logic fi_in;
`ifdef ALU_CHK_FAULT_INJ_EN
  assign fi_in = fault_inj;
`else
  assign fi_in = 1'b0;
`endif

  // Stage 1: operand capture
  logic             s1_vld_d, s1_vld_q;
  logic [WIDTH-1:0] a0_d, a0_q, b0_d, b0_q, a1_d, a1_q, b1_d, b1_q;
  logic [1:0]       sel0_d, sel0_q, sel1_d, sel1_q;
  logic             fi_d, fi_q;

  // Stage 2: registered results
  logic             s2_vld_d, s2_vld_q;
  logic [WIDTH-1:0] out0_d, out0_q, out1_d, out1_q, diff_d, diff_q;
  logic             carry0_d, carry0_q, carry1_d, carry1_q, carry_diff_d, carry_diff_q;

  // Error tracking
  logic             err_sticky_d, err_sticky_q;
  logic [CNT_W-1:0] err_count_d, err_count_q, cnt_base;
  mon_state_t       mon_state_d, mon_state_q;

  logic [WIDTH:0]   r0, r1;

  // Returns {carry, result}; SUB carry is the inverted borrow.
  function automatic logic [WIDTH:0] lane_op(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [1:0]       sel);
    logic [WIDTH:0] r;
    r = '0;
    case (sel)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  always_comb begin
    s1_vld_d = in_valid;
    a0_d     = a0;
    b0_d     = b0;
    a1_d     = a1;
    b1_d     = b1;
    sel0_d   = sel0;
    sel1_d   = sel1;
    fi_d     = fi_in;
  end

  always_comb begin
    s2_vld_d     = s1_vld_q;
    out0_d       = out0_q;
    out1_d       = out1_q;
    carry0_d     = carry0_q;
    carry1_d     = carry1_q;
    diff_d       = diff_q;
    carry_diff_d = carry_diff_q;
    r0           = lane_op(a0_q, b0_q, sel0_q);
    r1           = lane_op(a1_q, b1_q, sel1_q);
    r1[0]        = r1[0] ^ fi_q;
    if (s1_vld_q) begin
      out0_d       = r0[WIDTH-1:0];
      out1_d       = r1[WIDTH-1:0];
      carry0_d     = r0[WIDTH];
      carry1_d     = r1[WIDTH];
      diff_d       = r0[WIDTH-1:0] ^ r1[WIDTH-1:0];
      carry_diff_d = r0[WIDTH] ^ r1[WIDTH];
    end
  end

  assign mismatch = s2_vld_q && ((diff_q != '0) || carry_diff_q);

  // A mismatch in the same cycle as clr_err counts on top of the cleared state.
  always_comb begin
    cnt_base     = clr_err ? '0 : err_count_q;
    err_count_d  = cnt_base;
    err_sticky_d = clr_err ? 1'b0 : err_sticky_q;
    if (mismatch) begin
      err_sticky_d = 1'b1;
      if (cnt_base != {CNT_W{1'b1}}) err_count_d = cnt_base + 1'b1;
    end
  end

  always_comb begin
    mon_state_d = mon_state_q;
    case (mon_state_q)
      MON_OK:   if (mismatch) mon_state_d = MON_FAIL;
      MON_FAIL: if (clr_err && !mismatch) mon_state_d = MON_OK;
      default:  mon_state_d = MON_OK;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_vld_q     <= 1'b0;
      a0_q         <= '0;
      b0_q         <= '0;
      a1_q         <= '0;
      b1_q         <= '0;
      sel0_q       <= '0;
      sel1_q       <= '0;
      fi_q         <= 1'b0;
      s2_vld_q     <= 1'b0;
      out0_q       <= '0;
      out1_q       <= '0;
      carry0_q     <= 1'b0;
      carry1_q     <= 1'b0;
      diff_q       <= '0;
      carry_diff_q <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      mon_state_q  <= MON_OK;
    end else begin
      s1_vld_q     <= s1_vld_d;
      a0_q         <= a0_d;
      b0_q         <= b0_d;
      a1_q         <= a1_d;
      b1_q         <= b1_d;
      sel0_q       <= sel0_d;
      sel1_q       <= sel1_d;
      fi_q         <= fi_d;
      s2_vld_q     <= s2_vld_d;
      out0_q       <= out0_d;
      out1_q       <= out1_d;
      carry0_q     <= carry0_d;
      carry1_q     <= carry1_d;
      diff_q       <= diff_d;
      carry_diff_q <= carry_diff_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      mon_state_q  <= mon_state_d;
    end
  end

  assign out0       = out0_q;
  assign out1       = out1_q;
  assign carry0     = carry0_q;
  assign carry1     = carry1_q;
  assign diff       = diff_q;
  assign carry_diff = carry_diff_q;
  assign out_valid  = s2_vld_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign mon_state  = mon_state_q;

endmodule

// File: tb/tb_alu_lockstep_checker.sv
// Randomized and directed bench for alu_lockstep_checker (WIDTH=4, CNT_W=2) against an arithmetic reference model.
module tb_alu_lockstep_checker;

  localparam int W = 4;
  localparam int CW = 2;
  localparam int MOD = 16;
  localparam int CMAX = 3;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]    sel0 = '0, sel1 = '0;
  logic          fault_inj = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  out0, out1, diff;
  logic          carry0, carry1, carry_diff, out_valid, mismatch, err_sticky, mon_state;
  logic [CW-1:0] err_count;

  int total = 0;
  int fails = 0;

  alu_lockstep_checker #(.WIDTH(W), .CNT_W(CW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .in_valid(in_valid),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel0(sel0), .sel1(sel1),
`ifdef ALU_CHK_FAULT_INJ_EN
    .fault_inj(fault_inj),
`endif
    .clr_err(clr_err), .out0(out0), .out1(out1), .carry0(carry0), .carry1(carry1),
    .diff(diff), .carry_diff(carry_diff), .out_valid(out_valid), .mismatch(mismatch),
    .err_sticky(err_sticky), .err_count(err_count), .mon_state(mon_state)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Reference model: a two-deep queue of computed results plus error bookkeeping.
  typedef struct {
    bit v;
    int o0;
    int o1;
    bit c0;
    bit c1;
  } res_t;

  res_t pending[$];
  res_t m_out;
  int   m_cnt;
  bit   m_sticky, m_fail;

  function automatic void lane(input int a, input int b, input int sel, output int o, output bit c);
    case (sel)
      0: begin o = (a + b) % MOD; c = (a + b) >= MOD; end
      1: begin o = (a - b + MOD) % MOD; c = (a >= b); end
      2: begin o = a & b; c = 0; end
      default: begin o = a | b; c = 0; end
    endcase
  endfunction

  function automatic logic [20:0] dut_vec();
    return {out0, out1, carry0, carry1, diff, carry_diff, out_valid, mismatch,
            err_sticky, err_count, mon_state};
  endfunction

  function automatic logic [20:0] exp_vec();
    logic [W-1:0]  e0, e1;
    logic [CW-1:0] ec;
    bit            mm;
    e0 = m_out.o0[W-1:0];
    e1 = m_out.o1[W-1:0];
    ec = m_cnt[CW-1:0];
    mm = m_out.v && (m_out.o0 != m_out.o1 || m_out.c0 != m_out.c1);
    return {e0, e1, m_out.c0, m_out.c1, e0 ^ e1, m_out.c0 ^ m_out.c1, m_out.v, mm,
            m_sticky, ec, m_fail};
  endfunction

  task automatic drive(input bit v, input int x0, input int y0, input int s0,
                       input int x1, input int y1, input int s1);
    in_valid = v;
    a0 = x0[W-1:0]; b0 = y0[W-1:0]; sel0 = s0[1:0];
    a1 = x1[W-1:0]; b1 = y1[W-1:0]; sel1 = s1[1:0];
  endtask

  task automatic tick();
    res_t nxt, head;
    bit   mm;
    mm = m_out.v && (m_out.o0 != m_out.o1 || m_out.c0 != m_out.c1);
    lane(int'(a0), int'(b0), int'(sel0), nxt.o0, nxt.c0);
    lane(int'(a1), int'(b1), int'(sel1), nxt.o1, nxt.c1);
    if (fault_inj) nxt.o1 = nxt.o1 ^ 1;
    nxt.v = in_valid;
    @(posedge wb_clk_i);
    if (wb_rst_i) begin
      pending.delete();
      m_out = '{default: 0};
      m_cnt = 0; m_sticky = 0; m_fail = 0;
    end else begin
      pending.push_back(nxt);
      if (pending.size() > 1) begin
        head = pending.pop_front();
        if (head.v) m_out = head;
        else m_out.v = 0;
      end
      if (clr_err) begin m_cnt = 0; m_sticky = 0; m_fail = 0; end
      if (mm) begin
        m_sticky = 1; m_fail = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1; clr_err = 1'b0; fault_inj = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    wb_rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dut_vec() !== 21'd0) begin
      fails++; $display("FAIL reset_state got=%h want=0", dut_vec());
    end
  endtask

  task automatic test_add();
    drive(1, 9, 8, 0, 9, 8, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL add_latency_early out_valid=%b want=0", out_valid); end
    tick();
    total++;
    if ({out_valid, out0, out1, carry0, carry1, mismatch} !== {1'b1, 4'd1, 4'd1, 1'b1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL add_9_8 got v=%b o0=%0d o1=%0d c0=%b c1=%b mm=%b want 1 1 1 1 1 0",
                        out_valid, out0, out1, carry0, carry1, mismatch);
    end
    total++;
    if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL add_model got=%h want=%h", dut_vec(), exp_vec()); end
    tick();
    total++;
    if (out_valid !== 1'b0 || out0 !== 4'd1) begin
      fails++; $display("FAIL add_hold got v=%b o0=%0d want v=0 o0=1", out_valid, out0);
    end
  endtask

  task automatic test_sub_mismatch();
    do_reset();
    drive(1, 3, 5, 1, 3, 5, 1); tick();
    drive(1, 3, 5, 0, 3, 5, 1); tick();
    total++;
    if ({out0, out1, carry0, carry1, mismatch} !== {4'd14, 4'd14, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL sub_3_5 got o0=%0d o1=%0d c0=%b c1=%b mm=%b want 14 14 0 0 0",
                        out0, out1, carry0, carry1, mismatch);
    end
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    total++;
    if ({out0, out1, diff, carry_diff, mismatch, err_count} !== {4'd8, 4'd14, 4'd6, 1'b0, 1'b1, 2'd0}) begin
      fails++; $display("FAIL add_vs_sub got o0=%0d o1=%0d diff=%0d cd=%b mm=%b cnt=%0d want 8 14 6 0 1 0",
                        out0, out1, diff, carry_diff, mismatch, err_count);
    end
    tick();
    total++;
    if ({err_count, err_sticky, mon_state, mismatch} !== {2'd1, 1'b1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL err_after_mismatch got cnt=%0d st=%b mon=%b mm=%b want 1 1 1 0",
                        err_count, err_sticky, mon_state, mismatch);
    end
    total++;
    if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL sub_model got=%h want=%h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_saturate();
    int want[4] = '{1, 2, 3, 3};
    do_reset();
    drive(1, 1, 1, 0, 1, 1, 3);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      if (i >= 2) drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      total++;
      if (int'(err_count) != want[i] || err_count !== m_cnt[CW-1:0]) begin
        fails++; $display("FAIL saturate_%0d got cnt=%0d want=%0d", i, err_count, want[i]);
      end
    end
  endtask

  task automatic test_clr_collision();
    drive(1, 1, 1, 0, 1, 1, 3); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    clr_err = 1'b1; tick();
    total++;
    if ({err_count, err_sticky, mon_state} !== {2'd1, 1'b1, 1'b1}) begin
      fails++; $display("FAIL clr_vs_mismatch got cnt=%0d st=%b mon=%b want 1 1 1", err_count, err_sticky, mon_state);
    end
    tick();
    total++;
    if ({err_count, err_sticky, mon_state} !== {2'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL clr_alone got cnt=%0d st=%b mon=%b want 0 0 0", err_count, err_sticky, mon_state);
    end
    total++;
    if (dut_vec() !== exp_vec() || out0 !== 4'd2) begin
      fails++; $display("FAIL clr_keeps_pipe got=%h want=%h", dut_vec(), exp_vec());
    end
    clr_err = 1'b0;
  endtask

  task automatic test_reset_inflight();
    bit seen;
    do_reset();
    drive(1, 7, 2, 0, 7, 2, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    wb_rst_i = 1'b1; tick();
    wb_rst_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (dut_vec() !== 21'd0) seen = 1;
      tick();
    end
    total++;
    if (seen) begin fails++; $display("FAIL reset_inflight got=%h want=0 throughout", dut_vec()); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
            $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        a1 = a0; b1 = b0; sel1 = sel0;
      end
      clr_err = ($urandom_range(0, 7) == 0);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        fails++; errs++;
        if (errs < 10) $display("FAIL random_%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    clr_err = 1'b0;
  endtask

`ifdef ALU_CHK_FAULT_INJ_EN
  task automatic test_fault_inj();
    do_reset();
    drive(1, 15, 15, 2, 15, 15, 2); fault_inj = 1'b1; tick();
    drive(0, 0, 0, 0, 0, 0, 0); fault_inj = 1'b0; tick();
    total++;
    if ({out0, out1, diff, mismatch} !== {4'hF, 4'hE, 4'h1, 1'b1}) begin
      fails++; $display("FAIL fault_inj got o0=%h o1=%h diff=%h mm=%b want f e 1 1", out0, out1, diff, mismatch);
    end
  endtask
`endif

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 15 - i, i % 4, i, 15 - i, (i + 1) % 4);
      tick();
      if (i >= 2) begin
        total++;
        if (dut_vec() !== exp_vec() || out_valid !== 1'b1) begin
          fails++; $display("FAIL back_to_back_%0d got=%h want=%h", i, dut_vec(), exp_vec());
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mismatch();
    test_saturate();
    test_clr_collision();
    test_reset_inflight();
    test_back_to_back();
`ifdef ALU_CHK_FAULT_INJ_EN
    test_fault_inj();
`endif
    test_random();
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/alu_lockstep_checker.md
ALU_LOCKSTEP_CHECKER -- requirements
Module: alu_lockstep_checker

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width of each ALU lane (legal 2..32).
REQ-002 Parameter CNT_W, default 8, width of the saturating mismatch counter.
REQ-003 wb_clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 wb_rst_i  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand set valid this cycle.
REQ-006 a0, b0  input  WIDTH each  lane-0 operands.
REQ-007 a1, b1  input  WIDTH each  lane-1 operands.
REQ-008 sel0, sel1  input  2 each  lane op select (00 ADD, 01 SUB, 10 AND, 11 OR).
REQ-009 clr_err  input  1  clears sticky error, counter and FAIL state.
REQ-010 out0, out1  output  WIDTH each  registered lane results.
REQ-011 carry0, carry1  output  1 each  registered lane carry flags.
REQ-012 diff  output  WIDTH  out0 XOR out1, registered with results.
REQ-013 carry_diff  output  1  carry0 XOR carry1.
REQ-014 out_valid  output  1  result stage valid.
REQ-015 mismatch  output  1  out_valid AND (diff != 0 OR carry_diff).
REQ-016 err_sticky  output  1  set by any mismatch, held until clr_err/reset.
REQ-017 err_count  output  CNT_W  number of mismatching results, saturating.
REQ-018 mon_state  output  1  0 = MON_OK, 1 = MON_FAIL.

Function
REQ-019 Stage 1 SHALL capture a0,b0,a1,b1,sel0,sel1 and in_valid each cycle; stage 2 SHALL compute and register results; latency in_valid -> out_valid exactly 2 cycles, throughput one set per cycle.
REQ-020 ADD: {carry,out} = A + B, (WIDTH+1)-bit sum, upper bit to carry.
REQ-021 SUB: {carry,out} = A + ~B + 1; carry = 1 means no borrow (A >= B).
REQ-022 AND/OR: bitwise, carry = 0.
REQ-023 Stage registers SHALL advance every cycle; when stage valid is 0, out*/diff/carry* hold previous values and mismatch SHALL be 0.
REQ-024 On mismatch: err_sticky <= 1, err_count <= err_count + 1 unless at all-ones (saturate, no wrap), mon_state MON_OK -> MON_FAIL.
REQ-025 MON_FAIL -> MON_OK only on clr_err; no other transition leaves MON_FAIL.
REQ-026 clr_err and mismatch in same cycle: mismatch wins; err_sticky = 1, err_count = 1, mon_state = MON_FAIL.
REQ-027 clr_err does not affect pipeline contents or out_valid.

Reset
REQ-028 wb_rst_i sampled high SHALL on that edge zero both stage valids, out0, out1, carry0, carry1, diff, carry_diff, err_sticky, err_count; mon_state = MON_OK; takes priority over in_valid and clr_err.
REQ-029 Operands in flight at reset SHALL be discarded; first out_valid after reset release is 2 cycles after first in_valid.

Configuration
REQ-030 Macro ALU_CHK_FAULT_INJ_EN: when defined, input port fault_inj (1 bit) exists; stage-1 capture with fault_inj = 1 SHALL invert bit 0 of out1 of that result; when undefined, port absent and lane 1 unmodified.

Verification
REQ-031 WIDTH=4: a0=a1=9, b0=b1=8, sel=00 both, in_valid one cycle -> 2 cycles later out0=out1=1, carry0=carry1=1, mismatch=0.
REQ-032 a0=3,b0=5 SUB, a1=3,b1=5 SUB -> out=14, carry=0 both; then a0=3,b0=5 ADD vs a1=3,b1=5 SUB -> diff=14^14... (out0=8, out1=14) diff=6, carry_diff=0, mismatch=1, err_count=1, mon_state=1.
REQ-033 CNT_W=2, four consecutive mismatching sets -> err_count 1,2,3,3 (saturates).
REQ-034 clr_err asserted same cycle as mismatch with err_count=3 -> next err_count=1, err_sticky=1, mon_state=1; clr_err alone next -> 0, 0, MON_OK.
REQ-035 Reset asserted one cycle after in_valid -> out_valid never rises for that set, all outputs 0.
REQ-036 With ALU_CHK_FAULT_INJ_EN, identical lanes AND 0xF=0xF plus fault_inj=1 -> out1=0xE, diff=1, mismatch=1.
